// File: rtl/px16_spi_pkg.sv
// px16_spi_pkg: opcodes, parser state encoding and fill byte shared by the SPI command decoder
package px16_spi_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_WDATA_HI, S_WDATA_LO,
        S_BUS_WAIT, S_TURN, S_RDATA_HI, S_RDATA_LO, S_DISCARD
    } state_e;
    localparam logic [7:0] OP_READ        = 8'h01;
    localparam logic [7:0] OP_WRITE       = 8'h02;
    localparam logic [7:0] OP_READ_BURST  = 8'h81;
    localparam logic [7:0] OP_WRITE_BURST = 8'h82;
    localparam logic [7:0] UNDERRUN_FILL  = 8'hFF;
    function automatic logic is_cmd(input logic [7:0] b);
        return b inside {OP_READ, OP_WRITE, OP_READ_BURST, OP_WRITE_BURST};
    endfunction
endpackage

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses SPI byte frames (cmd, addr, payload) into single/burst bus reads and writes
module spi_cmd_decoder
    import px16_spi_pkg::*;
#(
    parameter int ADDR_W = 16,
    localparam int DATA_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              err_overrun,
    output logic              err_underrun
);
    state_e            state_q, state_d;
    logic              burst_q, burst_d, write_q, write_d, req_q, req_d, we_q, we_d;
    logic              rdy_q, rdy_d, uw_q, uw_d, ovr_q, ovr_d, und_q, und_d, pend_q, pend_d;
    logic [7:0]        ahi_q, ahi_d, rlo_q, rlo_d, tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack, go;

    assign ack = req_q & bus_ack;
    // a new frame cannot start while a transfer is still outstanding; it is held in pend_q
    assign go  = (frame_start | pend_q) & (~req_q | bus_ack);

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        write_d = write_q;
        ahi_d   = ahi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        we_d    = we_q;
        tx_d    = tx_q;
        rlo_d   = rlo_q;
        rdy_d   = rdy_q;
        uw_d    = uw_q;
        ovr_d   = ovr_q;
        und_d   = und_q;
        pend_d  = pend_q;
        if (ack) begin
            req_d = 1'b0;
            if (state_q == S_TURN) begin
                tx_d  = bus_rdata[DATA_W-1 -: 8];
                rlo_d = bus_rdata[7:0];
                rdy_d = 1'b1;
            end
            if (state_q == S_BUS_WAIT) begin
                state_d = burst_q ? S_WDATA_HI : S_DISCARD;
                addr_d  = burst_q ? addr_q + ADDR_W'(1) : addr_q;
            end
        end
        if (rx_valid) begin
            // S_TURN is the slot where late read data is an underrun, not an overrun
            if (req_q && state_q != S_TURN) begin
                ovr_d = 1'b1;
            end else begin
                case (state_q)
                    S_CMD: begin
                        burst_d = rx_data == OP_READ_BURST || rx_data == OP_WRITE_BURST;
                        write_d = rx_data == OP_WRITE || rx_data == OP_WRITE_BURST;
                        state_d = is_cmd(rx_data) ? S_ADDR_HI : S_DISCARD;
                    end
                    S_ADDR_HI: begin
                        ahi_d   = rx_data;
                        state_d = S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        addr_d  = ADDR_W'({ahi_q, rx_data});
                        req_d   = ~write_q;
                        we_d    = 1'b0;
                        state_d = write_q ? S_WDATA_HI : S_TURN;
                    end
                    S_WDATA_HI: begin
                        wdata_d[15:8] = rx_data;
                        state_d       = S_WDATA_LO;
                    end
                    S_WDATA_LO: begin
                        wdata_d[7:0] = rx_data;
                        req_d        = 1'b1;
                        we_d         = 1'b1;
                        state_d      = S_BUS_WAIT;
                    end
                    S_TURN: begin
                        tx_d    = rdy_q ? rlo_q : UNDERRUN_FILL;
                        uw_d    = ~rdy_q;
                        und_d   = und_q | ~rdy_q;
                        rdy_d   = 1'b0;
                        state_d = S_RDATA_HI;
                    end
                    S_RDATA_HI: begin
                        tx_d    = uw_q ? UNDERRUN_FILL : 8'h00;
                        req_d   = burst_q;
                        addr_d  = burst_q ? addr_q + ADDR_W'(1) : addr_q;
                        state_d = burst_q ? S_TURN : S_RDATA_LO;
                    end
                    S_RDATA_LO: begin
                        tx_d    = 8'h00;
                        state_d = S_DISCARD;
                    end
                    default: ;
                endcase
            end
        end
        if (frame_end) begin
            state_d = S_IDLE;
            tx_d    = 8'h00;
            rdy_d   = 1'b0;
            pend_d  = 1'b0;
        end
        if (go) begin
            state_d = S_CMD;
            tx_d    = 8'h00;
            rdy_d   = 1'b0;
            uw_d    = 1'b0;
            ovr_d   = 1'b0;
            und_d   = 1'b0;
            pend_d  = 1'b0;
        end else if (frame_start) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            burst_q <= 1'b0;
            write_q <= 1'b0;
            ahi_q   <= 8'h00;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            tx_q    <= 8'h00;
            rlo_q   <= 8'h00;
            rdy_q   <= 1'b0;
            uw_q    <= 1'b0;
            ovr_q   <= 1'b0;
            und_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            write_q <= write_d;
            ahi_q   <= ahi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            tx_q    <= tx_d;
            rlo_q   <= rlo_d;
            rdy_q   <= rdy_d;
            uw_q    <= uw_d;
            ovr_q   <= ovr_d;
            und_q   <= und_d;
            pend_q  <= pend_d;
        end
    end

    assign tx_data      = tx_q;
    assign bus_req      = req_q;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign err_overrun  = ovr_q;
    assign err_underrun = und_q;
endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter ADDR_W, default 16, bus address width.
REQ-002 Parameter DATA_W, fixed 16, bus data width (two SPI bytes per word, MSB first).
REQ-003 clk_in  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 frame_start  in  1  one-cycle pulse: SPI chip-select asserted (already synchronised to clk_in).
REQ-006 frame_end  in  1  one-cycle pulse: SPI chip-select released.
REQ-007 rx_valid  in  1  one-cycle pulse: rx_data holds a complete received byte.
REQ-008 rx_data  in  8  received byte.
REQ-009 tx_data  out  8  byte the SPI slave shifts out on the next byte slot; sampled by the slave at each rx_valid.
REQ-010 bus_req  out  1  bus request, held until bus_ack.
REQ-011 bus_we  out  1  1 = write, 0 = read; stable while bus_req is high.
REQ-012 bus_addr  out  ADDR_W  word address; stable while bus_req is high.
REQ-013 bus_wdata  out  16  write data; stable while bus_req is high.
REQ-014 bus_ack  in  1  one-cycle completion; may arrive in the same cycle bus_req rises or any later cycle.
REQ-015 bus_rdata  in  16  read data, valid when bus_ack is high and bus_we is 0.
REQ-016 err_overrun  out  1  sticky: byte arrived while a bus transfer was pending.
REQ-017 err_underrun  out  1  sticky: read data not ready when its byte slot started.

Function
REQ-018 Frame format: byte0 = command, byte1 = addr[15:8], byte2 = addr[7:0], then payload; frame_start always resets the parser to CMD.
REQ-019 Commands: 0x01 READ, 0x02 WRITE, 0x81 READ_BURST, 0x82 WRITE_BURST; any other value sends the FSM to DISCARD until frame_end.
REQ-020 FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, WDATA_HI, WDATA_LO, BUS_WAIT, TURN, RDATA_HI, RDATA_LO, DISCARD.
REQ-021 WRITE: two payload bytes form {hi,lo}; bus_req=1 and bus_we=1 are asserted in the cycle after the rx_valid of the lo byte.
REQ-022 READ: bus_req=1 and bus_we=0 are asserted in the cycle after the rx_valid of the addr lo byte; the master sends one dummy byte (TURN), then two bytes that return rdata[15:8] and rdata[7:0].
REQ-023 bus_rdata is latched on bus_ack; tx_data = rdata[15:8] from the cycle after ack, switches to rdata[7:0] after the next rx_valid, then returns to 0x00.
REQ-024 If the TURN byte's rx_valid arrives before bus_ack, err_underrun is set, and both data slots return 0xFF.
REQ-025 Burst variants: after each completed word, bus_addr increments by 1, wrapping at 2^ADDR_W-1 to 0; READ_BURST issues the next read immediately after RDATA_HI is consumed (prefetch); frame_end terminates the burst.
REQ-026 At most one bus transfer is outstanding; a byte received while bus_req is high is dropped and sets err_overrun (except the TURN byte of REQ-024).
REQ-027 frame_end in any state returns the FSM to IDLE; if bus_req is high it stays high until bus_ack, and any read data returned is discarded.
REQ-028 frame_start during a pending transfer is ignored until bus_ack; err flags clear on frame_start.
REQ-029 tx_data = 0x00 in every state not covered by REQ-023/024.
REQ-030 rx_valid and frame_end in the same cycle: the byte is processed first, then the FSM aborts; a write whose lo byte arrives in that cycle is still issued.

Reset
REQ-031 While rst_n=0: FSM=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, tx_data=0x00, err_overrun=0, err_underrun=0.
REQ-032 Reset mid-transfer drops bus_req asynchronously; the bus side tolerates this.

Structure
REQ-033 The command opcodes, state encoding and the 0xFF underrun fill value are defined in shared package px16_spi_pkg.
REQ-034 The module is a single module with no sub-modules; address increment and wrap are inline.

Verification
REQ-035 Frame 02 12 34 AB CD -> one bus_req with we=1, addr=0x1234, wdata=0xABCD, asserted the cycle after the 5th rx_valid.
REQ-036 Frame 01 00 10 xx xx xx with ack after 2 cycles, rdata=0xBEEF -> tx_data 0xBE on the 4th slot, 0xEF on the 5th slot, 0x00 after that.
REQ-037 Frame 81 FF FF plus 8 dummy bytes -> reads to 0xFFFF then 0x0000; wrap is verified.
REQ-038 Read with ack delayed past the TURN byte -> err_underrun=1, tx_data=0xFF; a later frame_start clears the flag.
REQ-039 frame_end during a pending write with ack 5 cycles later -> bus_req held until ack, then FSM=IDLE, no second request.
REQ-040 Unknown command 0x55 followed by 4 bytes -> no bus_req, tx_data stays 0x00; rst_n pulse mid-burst -> all outputs take their reset values.
